// File: rtl/lab5_et_core_oci_dct_packer.sv
// rtl/lab5_et_core_oci_dct_packer.sv - packs 2-bit DCT trace codes into 15-code frames with a one-deep output register.
// Optional dropped-code counter: define LAB5_ET_CORE_DCT_DROP_CNT_EN.
module lab5_et_core_oci_dct_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trace_en,
  input  logic        dct_valid,
  input  logic [1:0]  dct_code,
  input  logic        flush,
  input  logic        frame_ready,
  input  logic        overflow_clr,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        frame_valid,
  output logic [29:0] frame_data,
  output logic [3:0]  frame_count,
  output logic        overflow,
  output logic [7:0]  dropped_cnt
);

  logic        accept;
  logic [29:0] post_buf;
  logic [3:0]  post_cnt;
  logic        close;
  logic        load;
  logic        drop;

  // The accumulator is viewed "after" this cycle's event so a same-cycle flush includes it.
  always_comb begin
    accept   = trace_en & dct_valid & (dct_code != 2'b00);
    post_buf = accept ? {dct_buffer[27:0], dct_code} : dct_buffer;
    post_cnt = dct_count + {3'b000, accept};
    close    = trace_en & ((accept & (post_cnt == 4'd15)) | (flush & (post_cnt != 4'd0)));
    load     = close & (~frame_valid | frame_ready);
    drop     = close & ~load;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (!trace_en || close) begin
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (accept) begin
      dct_buffer <= post_buf;
      dct_count  <= post_cnt;
    end
  end

  // Payload only changes on a load, so it stays stable while the frame is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_count <= '0;
    end else if (load) begin
      frame_valid <= 1'b1;
      frame_data  <= post_buf;
      frame_count <= post_cnt;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef LAB5_ET_CORE_DCT_DROP_CNT_EN
  logic [7:0] cnt_base;
  logic [8:0] cnt_sum;

  // A clear in the same cycle as a drop restarts the count from this drop.
  always_comb begin
    cnt_base = overflow_clr ? 8'd0 : dropped_cnt;
    cnt_sum  = {1'b0, cnt_base} + {5'd0, post_cnt};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dropped_cnt <= '0;
    end else if (drop) begin
      dropped_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end else if (overflow_clr) begin
      dropped_cnt <= '0;
    end
  end
`else
  assign dropped_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_lab5_et_core_oci_dct_packer.sv
// tb/tb_lab5_et_core_oci_dct_packer.sv - directed and randomized checks of the DCT packer against a queue-based model.
module tb_lab5_et_core_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trace_en, dct_valid, flush, frame_ready, overflow_clr;
  logic [1:0]  dct_code;
  logic [29:0] dct_buffer, frame_data;
  logic [3:0]  dct_count, frame_count;
  logic        frame_valid, overflow;
  logic [7:0]  dropped_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: pending codes as a queue, plus the held frame.
  int          q[$];
  bit          m_fv;
  logic [29:0] m_fd;
  int          m_fc;
  bit          m_ov;
  int          m_dc;

`ifdef LAB5_ET_CORE_DCT_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  lab5_et_core_oci_dct_packer dut (
    .clk(clk), .reset_n(reset_n), .trace_en(trace_en), .dct_valid(dct_valid),
    .dct_code(dct_code), .flush(flush), .frame_ready(frame_ready),
    .overflow_clr(overflow_clr), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .frame_valid(frame_valid), .frame_data(frame_data), .frame_count(frame_count),
    .overflow(overflow), .dropped_cnt(dropped_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] pack(input int codes[$]);
    logic [29:0] v = '0;
    foreach (codes[i]) v = {v[27:0], 2'(codes[i])};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fv = 0; m_fd = '0; m_fc = 0; m_ov = 0; m_dc = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dct_count"}, 32'(dct_count), 32'(q.size()));
    chk({tag, ".dct_buffer"}, 32'(dct_buffer), 32'(pack(q)));
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
    if (m_fv) begin
      chk({tag, ".frame_data"}, 32'(frame_data), 32'(m_fd));
      chk({tag, ".frame_count"}, 32'(frame_count), 32'(m_fc));
    end
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ov));
    chk({tag, ".dropped_cnt"}, 32'(dropped_cnt), DROP_EN ? 32'(m_dc) : 32'd0);
  endtask

  // Drive one cycle, advance the model by the specification's rules, then compare after the edge.
  task automatic step(input string tag, input bit te, input bit v, input int code,
                      input bit fl, input bit rdy, input bit clr);
    bit acc, cls;
    trace_en = te; dct_valid = v; dct_code = 2'(code); flush = fl;
    frame_ready = rdy; overflow_clr = clr;
    acc = te && v && code != 0;
    cls = 0;
    if (clr) begin m_ov = 0; m_dc = 0; end
    if (!te) q.delete();
    else begin
      if (acc) q.push_back(code);
      cls = (acc && q.size() == 15) || (fl && q.size() >= 1);
    end
    if (cls) begin
      if (!m_fv || rdy) begin
        m_fv = 1; m_fd = pack(q); m_fc = q.size();
      end else begin
        m_ov = 1;
        m_dc = (m_dc + q.size() > 255) ? 255 : m_dc + q.size();
      end
      q.delete();
    end else if (m_fv && rdy) m_fv = 0;
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".dct_buffer"}, 32'(dct_buffer), 32'd0);
    chk({tag, ".dct_count"}, 32'(dct_count), 32'd0);
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, ".frame_data"}, 32'(frame_data), 32'd0);
    chk({tag, ".frame_count"}, 32'(frame_count), 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'd0);
    chk({tag, ".dropped_cnt"}, 32'(dropped_cnt), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    trace_en = 0; dct_valid = 0; dct_code = 0; flush = 0; frame_ready = 0; overflow_clr = 0;
    model_reset();
    #3;
    check_all_zero("reset");
    #9 reset_n = 1'b1;

    // Full 15-code frame of "taken".
    for (int i = 0; i < 15; i++) step("full15", 1, 1, 2, 0, 1, 0);
    chk("full15.fv", 32'(frame_valid), 32'd1);
    chk("full15.fd", 32'(frame_data), 32'h2AAAAAAA);
    chk("full15.fc", 32'(frame_count), 32'd15);
    chk("full15.cnt0", 32'(dct_count), 32'd0);
    step("full15.pulse", 1, 0, 0, 0, 1, 0);
    chk("full15.fv_low", 32'(frame_valid), 32'd0);

    // 01,10,01 then flush; a second empty flush makes nothing.
    step("fl3", 1, 1, 1, 0, 1, 0);
    step("fl3", 1, 1, 2, 0, 1, 0);
    step("fl3", 1, 1, 1, 0, 1, 0);
    step("fl3", 1, 0, 0, 1, 1, 0);
    chk("fl3.fd", 32'(frame_data), 32'h19);
    chk("fl3.fc", 32'(frame_count), 32'd3);
    step("fl3.drain", 1, 0, 0, 0, 1, 0);
    step("fl_empty", 1, 0, 0, 1, 1, 0);
    chk("fl_empty.fv", 32'(frame_valid), 32'd0);

    // Event and flush in the same cycle; also a 00 code that must be ignored.
    step("same", 1, 1, 1, 0, 1, 0);
    step("same.code00", 1, 1, 0, 0, 1, 0);
    step("same", 1, 1, 1, 0, 1, 0);
    step("same", 1, 1, 2, 1, 1, 0);
    chk("same.fd", 32'(frame_data), 32'h16);
    chk("same.fc", 32'(frame_count), 32'd3);
    step("same.drain", 1, 0, 0, 0, 1, 0);

    // Stalled output: first frame held, second dropped; reserved code 11 passes through.
    step("ovf", 1, 1, 3, 0, 0, 0);
    step("ovf", 1, 1, 1, 1, 0, 0);
    step("ovf.hold", 1, 1, 2, 0, 0, 0);
    step("ovf.hold", 1, 1, 2, 0, 0, 0);
    step("ovf.hold", 1, 1, 3, 1, 0, 0);
    chk("ovf.fd_stable", 32'(frame_data), 32'hD);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.dropped", 32'(dropped_cnt), DROP_EN ? 32'd3 : 32'd0);
    step("ovf.clr", 1, 0, 0, 0, 0, 1);
    chk("ovf.clr_flag", 32'(overflow), 32'd0);
    chk("ovf.clr_cnt", 32'(dropped_cnt), 32'd0);

    // Async reset with 7 codes pending and a frame held.
    for (int i = 0; i < 7; i++) step("rst7", 1, 1, 1 + (i % 3), 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    #3 reset_n = 1'b1;
    step("post_rst", 1, 0, 0, 0, 1, 0);
    step("post_rst", 1, 0, 0, 0, 1, 0);

    // Disable with 5 codes held; events while disabled are ignored.
    for (int i = 0; i < 5; i++) step("dis", 1, 1, 2, 0, 1, 0);
    step("dis.off", 0, 0, 0, 0, 1, 0);
    chk("dis.cnt0", 32'(dct_count), 32'd0);
    step("dis.ev", 0, 1, 1, 0, 1, 0);
    step("dis.ev", 0, 1, 3, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit te, v, fl, rdy, clr;
      int code;
      te   = ($urandom_range(0, 19) != 0);
      v    = ($urandom_range(0, 3) != 0);
      code = $urandom_range(0, 3);
      fl   = te && ($urandom_range(0, 11) == 0);
      rdy  = ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 29) == 0);
      step("rand", te, v, code, fl, rdy, clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
